// File: rtl/seq_comparer.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands SLICE bits per cycle, MSB slice first.
// Optional macro EARLY_EXIT_EN ends the walk on the first differing slice.
module seq_comparer #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       ur,
   output logic [2:0]       sr,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready only in IDLE, out_valid only in DONE.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic             ug, ul, ug_n, ul_n;
   logic             sg_n, sl_n;
   logic [SLICE-1:0] a_sl, b_sl;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign a_sl = a_q[idx*SLICE +: SLICE];
   assign b_sl = b_q[idx*SLICE +: SLICE];

   always_comb begin
      state_n = state;
      ug_n    = ug;
      ul_n    = ul;
      case (state)
         IDLE: if (in_valid) state_n = RUN;
         RUN: begin
            // The first (most significant) difference wins; lower slices never override it.
            if (!(ug || ul) && (a_sl != b_sl)) begin
               ug_n = (a_sl > b_sl);
               ul_n = (a_sl < b_sl);
            end
`ifdef EARLY_EXIT_EN
            if (ug_n || ul_n || (idx == '0)) state_n = DONE;
`else
            if (idx == '0) state_n = DONE;
`endif
         end
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Differing sign bits decide the signed relation outright.
   always_comb begin
      sg_n = ug_n;
      sl_n = ul_n;
      case ({a_q[WIDTH-1], b_q[WIDTH-1]})
         2'b01: begin sg_n = 1'b1; sl_n = 1'b0; end
         2'b10: begin sg_n = 1'b0; sl_n = 1'b1; end
         default: begin sg_n = ug_n; sl_n = ul_n; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         idx   <= '0;
         ug    <= 1'b0;
         ul    <= 1'b0;
         ur    <= 3'b000;
         sr    <= 3'b000;
      end else begin
         state <= state_n;
         ug    <= ug_n;
         ul    <= ul_n;
         if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
            idx <= IW'(NSLICE - 1);
            ug  <= 1'b0;
            ul  <= 1'b0;
         end else if (state == RUN) begin
            if (idx != '0) idx <= idx - IW'(1);
            if (state_n == DONE) begin
               ur <= {ul_n, ul_n | ug_n, ug_n};
               sr <= {sl_n, sl_n | sg_n, sg_n};
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_comparer.sv
// Bench for seq_comparer: directed and random compares against a reference model,
// with a queue-based scoreboard checked by an independent monitor.
module tb_seq_comparer;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             in_ready, out_valid, busy;
   logic [2:0]       ur, sr;

   seq_comparer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .ur(ur), .sr(sr), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [5:0] exp_q[$];
   int         lat_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   logic       prev_valid = 1'b0;
   logic       drop_chk = 1'b0;
   logic       done_req = 1'b0;

   // Reference relations straight from integer comparison.
   function automatic logic [5:0] ref_rel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [2:0] u, s;
      u = (x < y) ? 3'b110 : (x > y) ? 3'b011 : 3'b000;
      s = ($signed(x) < $signed(y)) ? 3'b110 : ($signed(x) > $signed(y)) ? 3'b011 : 3'b000;
      return {u, s};
   endfunction

   function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] d;
      int top;
      d = x ^ y;
      top = -1;
      for (int i = 0; i < WIDTH; i++) if (d[i]) top = i;
`ifdef EARLY_EXIT_EN
      if (top < 0) return NSLICE;
      return NSLICE - top / SLICE;
`else
      return (top < -1) ? 0 : NSLICE;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_ur", ur, 0);
         chk("rst_sr", sr, 0);
         exp_q.delete();
         lat_q.delete();
         prev_valid = 1'b0;
         drop_chk = 1'b0;
      end else begin
         if (drop_chk) chk("out_valid_drop", out_valid, 0);
         if (out_valid && !prev_valid) begin
            chk("latency_pending", lat_q.size() != 0, 1);
            if (lat_q.size() != 0) chk("latency", cyc, lat_q.pop_front());
         end
         if (out_valid) begin
            chk("in_ready_done", in_ready, 0);
            chk("busy_done", busy, 1);
            chk("result_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               chk("ur", ur, exp_q[0][5:3]);
               chk("sr", sr, exp_q[0][2:0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         drop_chk = out_valid && out_ready;
         prev_valid = out_valid;
         if (done_req) begin
            chk("queue_empty", exp_q.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input int hold);
      int t;
      @(posedge clk); #1;
      a = ta; b = tb; in_valid = 1'b1; out_ready = (hold == 0);
      @(negedge clk);
      t = 0;
      while (!in_ready) begin
         if (t++ > 50) begin $display("FAIL accept_timeout"); $fatal(1); end
         @(negedge clk);
      end
      exp_q.push_back(ref_rel(ta, tb));
      lat_q.push_back(cyc + 1 + ref_lat(ta, tb));
      @(posedge clk); #1;
      a = $urandom; b = $urandom; in_valid = (hold > 0);
      @(negedge clk);
      t = 0;
      while (!out_valid) begin
         if (t++ > 50) begin $display("FAIL result_timeout"); $fatal(1); end
         @(negedge clk);
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         @(posedge clk); #1;
         in_valid = 1'b0; out_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      issue(32'h0000_0005, 32'h0000_0005, 0);
      issue(32'h8000_0000, 32'h0000_0001, 0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      issue(32'h0000_0003, 32'h0000_0007, 0);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 0);
      issue(32'h1234_5678, 32'h1234_5600, 3);
      // Abandon a compare with reset two edges into RUN.
      ra = $urandom;
      @(posedge clk); #1;
      a = ra; b = ra; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      issue(32'h0000_0001, 32'h0000_0002, 0);
      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = ra;
            2: rb = ra ^ (WIDTH'($urandom_range(1, 255)) << (SLICE * $urandom_range(0, NSLICE - 1)));
            default: rb = ra ^ 32'h8000_0000;
         endcase
         issue(ra, rb, $urandom_range(0, 3));
      end
      @(posedge clk); #1 done_req = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule

// File: doc/seq_comparer.md
Name: seq_comparer

Overview:
- Multi-cycle, parametrised magnitude comparator.
- Compares two WIDTH-bit operands one SLICE-bit slice per cycle, MSB slice first.
- Produces unsigned and signed 3-bit relation codes, using the same {lt, ne, gt} encoding as the existing combinational comparator.
- Sits behind a valid/ready handshake so wide operands (e.g. 64/128-bit) can be compared without a full-width carry chain in the critical path.

Parameters:
- WIDTH, 32, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 8, bits compared per cycle. NSLICE = WIDTH/SLICE, must be ≥ 1.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  ur/sr valid.
- out_ready  input  1  consumer accepts result.
- ur  output  3  unsigned relation {lt, ne, gt}; 000 means equal.
- sr  output  3  signed (two's complement) relation {lt, ne, gt}; 000 means equal.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, ur=sr=000, internal flags cleared. Reset mid-operation abandons the compare; no result is emitted.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready, latch a, b; set idx=NSLICE-1; clear ug/ul; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Compare slice idx of latched A vs B, unsigned.
  - If no difference has been recorded yet and the slices differ, set ug=(A_slice>B_slice) and ul=(A_slice<B_slice).
  - With EARLY_EXIT_EN defined: go to DONE in the same cycle the first difference is found.
  - Otherwise: if idx==0, go to DONE; else decrement idx.
  - Once a difference is recorded, it is never overwritten by lower slices.
- Result formation on entering DONE (registered):
  - ur = {ul, ul|ug, ug}.
  - Signed result from latched sign bits A[WIDTH-1], B[WIDTH-1]:
    - 01 → sg=1, sl=0.
    - 10 → sg=0, sl=1.
    - 00 or 11 → sg=ug, sl=ul.
    - Equal operands → sg=sl=0.
  - sr = {sl, sl|sg, sg}.
- DONE:
  - Hold ur/sr/out_valid stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops the next cycle.
  - in_valid is ignored; there are no back-to-back overlapping accepts.
  - ur/sr keep their last values in IDLE until the next result.
- Latency, counted in rising edges from the accept edge to out_valid=1:
  - Without early exit: fixed NSLICE+0, i.e. out_valid is high after edge NSLICE.
  - With early exit: k edges, where k = NSLICE - (index of the highest differing slice); equal operands take NSLICE.
- Throughput: one compare per NSLICE+2 cycles at best (accept, RUN×k, DONE with out_ready=1).
- NSLICE=1: RUN lasts one cycle; behaviour is otherwise identical.
- Operand inputs are sampled only at accept; later changes to a/b have no effect.

Optional Feature:
- Macro: EARLY_EXIT_EN.
- Defined: RUN terminates on the first differing slice, giving variable latency of 1..NSLICE.
- Undefined: RUN always walks all NSLICE slices, giving fixed latency of NSLICE. ur/sr values are identical in both builds.

Test Plan (WIDTH=32, SLICE=8, NSLICE=4):
- a=0x00000005, b=0x00000005, out_ready=1 → ur=000, sr=000; out_valid after 4 edges in both builds.
- a=0x80000000, b=0x00000001 → ur=011, sr=110; out_valid after 1 edge with EARLY_EXIT_EN, after 4 edges without.
- a=0xFFFFFFFF, b=0xFFFFFFFE → ur=011, sr=011; out_valid after 4 edges in both builds (difference is in slice 0).
- a=0x00000003, b=0x00000007 → ur=110, sr=110; then a=0x7FFFFFFF, b=0x80000000 → ur=110, sr=011.
- Back-pressure: out_ready=0 for 3 cycles in DONE, with in_valid=1 and new a/b → out_valid and ur/sr stable, in_ready=0. Raise out_ready → IDLE next cycle, new operands accepted.
- Assert rst during RUN (edge 2) → out_valid=0, ur=sr=000, in_ready=1 immediately (async), no stale result after rst is released.
